// File: rtl/regfile_seq.sv
// Regfile front-end: clears x1..x(N-1) after reset, passes core traffic, dumps register pairs on request.
// Regfile-facing outputs are combinational from state; dump port registered (1 cycle); stall holds the core outside RUN.
module regfile_seq #(
  parameter int              XLEN       = 32,
  parameter int              NUM_REGS   = 32,
  parameter int              ADDR_W     = 5,
  parameter logic [XLEN-1:0] INIT_VALUE = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                core_RegWrite,
  input  logic [ADDR_W-1:0]   core_rd,
  input  logic [XLEN-1:0]     core_Result,
  input  logic [ADDR_W-1:0]   core_rs1,
  input  logic [ADDR_W-1:0]   core_rs2,
  output logic                RegWrite,
  output logic [ADDR_W-1:0]   rd,
  output logic [XLEN-1:0]     Result,
  output logic [ADDR_W-1:0]   rs1,
  output logic [ADDR_W-1:0]   rs2,
  input  logic [XLEN-1:0]     RD1,
  input  logic [XLEN-1:0]     RD2,
  output logic                stall,
  output logic                init_done,
  input  logic                dump_req,
  output logic                dump_valid,
  output logic [ADDR_W-1:0]   dump_idx,
  output logic [2*XLEN-1:0]   dump_data,
  output logic                dump_done
);

  typedef enum logic [1:0] {
    INIT = 2'd0,
    RUN  = 2'd1,
    DUMP = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] CNT_LAST_INIT = ADDR_W'(NUM_REGS - 1);
  localparam logic [ADDR_W-1:0] CNT_LAST_DUMP = ADDR_W'(NUM_REGS - 2);
  localparam logic [ADDR_W-1:0] CNT_STEP_DUMP = ADDR_W'(2);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] cnt, cnt_nxt;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    RegWrite  = 1'b0;
    rd        = '0;
    Result    = '0;
    rs1       = '0;
    rs2       = '0;
    stall     = 1'b1;
    case (state)
      INIT: begin
        RegWrite = 1'b1;
        rd       = cnt;
        Result   = INIT_VALUE;
        cnt_nxt  = cnt + 1'b1;
        if (cnt == CNT_LAST_INIT) state_nxt = RUN;
      end
      RUN: begin
        // x0 is hardwired zero, so core writes to it are dropped here
        RegWrite = core_RegWrite && (core_rd != '0);
        rd       = core_rd;
        Result   = core_Result;
        rs1      = core_rs1;
        rs2      = core_rs2;
        stall    = 1'b0;
        if (dump_req) begin
          state_nxt = DUMP;
          cnt_nxt   = '0;
        end
      end
      DUMP: begin
        rs1     = cnt;
        rs2     = cnt + 1'b1;
        cnt_nxt = cnt + CNT_STEP_DUMP;
        if (cnt == CNT_LAST_DUMP) state_nxt = RUN;
      end
      default: begin
        state_nxt = INIT;
        cnt_nxt   = ADDR_W'(1);
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= INIT;
      cnt        <= ADDR_W'(1);
      init_done  <= 1'b0;
      dump_valid <= 1'b0;
      dump_idx   <= '0;
      dump_data  <= '0;
      dump_done  <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      dump_valid <= (state == DUMP);
      dump_done  <= (state == DUMP) && (cnt == CNT_LAST_DUMP);
      if (state == INIT && cnt == CNT_LAST_INIT) init_done <= 1'b1;
      // idx/data keep the last pair once the dump ends
      if (state == DUMP) begin
        dump_idx  <= cnt;
        dump_data <= {RD2, RD1};
      end
    end
  end

endmodule
